serial_demux_n: RTL

- Parametrised serial-to-parallel demultiplexer, next generation of the lab's 4-port serial demux top level.
- Decodes a framed bit stream from one serial input: start bit, channel address, length field, payload bits.
- Routes each payload bit to the addressed channel output, and shows remaining payload count on a seven-segment display.
- Sits between the board's debounced serial/clock-enable inputs and the LED/SSD pins; controller and datapath live in one module.

---
 rtl/serial_demux_n.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/serial_demux_n.sv
// rtl/serial_demux_n.sv - framed serial-to-parallel channel demultiplexer with remaining-count display
//
// Purpose:
//   Decodes a framed bit stream (start bit, channel address, length, payload)
//   arriving on serIn. Payload bits are steered to the addressed channel
//   output. The number of payload bits still to come is shown on a
//   seven-segment display. All state advances only on clock edges where
//   clkEn is high, so the bit rate is set by clkEn.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   clkEn       in   bit-rate enable
//   serIn       in   serial frame input, idles at IDLE_LVL
//   p           out  NUM_CH channel outputs; p[chSel] = serIn during payload
//   serOutValid out  high while the payload is being delivered
//   done        out  high while in the one-enabled-cycle DONE state
//   chSel       out  address of the current/last frame (updated once the address is complete)
//   cntRem      out  remaining payload bits
//   ssdOut      out  active-high segments {g,f,e,d,c,b,a} for the low nibble of cntRem

module serial_demux_n #(
  parameter int ADDR_W    = 2,
  parameter int CNT_W     = 4,
  parameter int MSB_FIRST = 1,
  parameter int IDLE_LVL  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clkEn,
  input  logic                 serIn,
  output logic [2**ADDR_W-1:0] p,
  output logic                 serOutValid,
  output logic                 done,
  output logic [ADDR_W-1:0]    chSel,
  output logic [CNT_W-1:0]     cntRem,
  output logic [6:0]           ssdOut
);

  localparam int NUM_CH = 2**ADDR_W;

  // One counter serves both header fields, so it must reach the longer one.
  localparam int FIELD_MAX = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;
  localparam int BC_W      = $clog2(FIELD_MAX + 1);

  localparam logic [BC_W-1:0]  ADDR_LAST = BC_W'(ADDR_W - 1);
  localparam logic [BC_W-1:0]  LEN_LAST  = BC_W'(CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic             START_BIT = (IDLE_LVL == 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_PAYLOAD,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [BC_W-1:0]     bit_cnt;
  logic [BC_W-1:0]     bit_cnt_nx;
  logic [ADDR_W-1:0]   addr_sh;
  logic [ADDR_W-1:0]   addr_nx;
  logic [ADDR_W-1:0]   addr_shift;
  logic [ADDR_W-1:0]   ch_nx;
  logic [CNT_W-1:0]    cnt_nx;
  logic [CNT_W-1:0]    len_shift;
  logic [3:0]          nibble;

  // Field assembly: MSB-first shifts left inserting at bit 0,
  // LSB-first shifts right inserting at the top bit. The length is
  // assembled directly in cntRem so it is ready when the payload starts.
  always_comb begin
    if (MSB_FIRST != 0) begin
      addr_shift = (addr_sh << 1) | ADDR_W'(serIn);
      len_shift  = (cntRem << 1) | CNT_W'(serIn);
    end else begin
      addr_shift = (addr_sh >> 1) | (ADDR_W'(serIn) << (ADDR_W - 1));
      len_shift  = (cntRem >> 1) | (CNT_W'(serIn) << (CNT_W - 1));
    end
  end

  // State and datapath registers; nothing moves without clkEn.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      addr_sh <= '0;
      chSel   <= '0;
      cntRem  <= '0;
    end else if (clkEn) begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      addr_sh <= addr_nx;
      chSel   <= ch_nx;
      cntRem  <= cnt_nx;
    end
  end

  // Next-state, next-datapath and frame outputs.
  always_comb begin
    state_nx    = state;
    bit_cnt_nx  = bit_cnt;
    addr_nx     = addr_sh;
    ch_nx       = chSel;
    cnt_nx      = cntRem;
    p           = '0;
    serOutValid = 1'b0;
    done        = 1'b0;

    case (state)
      S_IDLE: begin
        if (serIn == START_BIT) begin
          state_nx   = S_ADDR;
          bit_cnt_nx = '0;
        end
      end

      S_ADDR: begin
        addr_nx = addr_shift;
        if (bit_cnt == ADDR_LAST) begin
          // chSel is published only once the whole address is in, so the
          // previous frame's channel stays visible while the address shifts.
          ch_nx      = addr_shift;
          bit_cnt_nx = '0;
          state_nx   = S_LEN;
        end else begin
          bit_cnt_nx = bit_cnt + BC_W'(1);
        end
      end

      S_LEN: begin
        cnt_nx = len_shift;
        if (bit_cnt == LEN_LAST) begin
          bit_cnt_nx = '0;
          state_nx   = (len_shift == '0) ? S_DONE : S_PAYLOAD;
        end else begin
          bit_cnt_nx = bit_cnt + BC_W'(1);
        end
      end

      S_PAYLOAD: begin
        // The channel output is a straight combinational path from serIn,
        // so it tracks serIn even between enables.
        serOutValid = 1'b1;
        p[chSel]    = serIn;
        // Saturating decrement: the last bit lands on zero and never wraps.
        if (cntRem <= CNT_ONE) begin
          cnt_nx   = '0;
          state_nx = S_DONE;
        end else begin
          cnt_nx = cntRem - CNT_ONE;
        end
      end

      S_DONE: begin
        // serIn is deliberately ignored here; a new frame needs a start
        // bit seen from IDLE.
        done     = 1'b1;
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Seven-segment decode of the low nibble of cntRem, {g,f,e,d,c,b,a}.
  always_comb begin
    nibble = 4'(cntRem);
    case (nibble)
      4'h0:    ssdOut = 7'h3F;
      4'h1:    ssdOut = 7'h06;
      4'h2:    ssdOut = 7'h5B;
      4'h3:    ssdOut = 7'h4F;
      4'h4:    ssdOut = 7'h66;
      4'h5:    ssdOut = 7'h6D;
      4'h6:    ssdOut = 7'h7D;
      4'h7:    ssdOut = 7'h07;
      4'h8:    ssdOut = 7'h7F;
      4'h9:    ssdOut = 7'h6F;
      4'hA:    ssdOut = 7'h77;
      4'hB:    ssdOut = 7'h7C;
      4'hC:    ssdOut = 7'h39;
      4'hD:    ssdOut = 7'h5E;
      4'hE:    ssdOut = 7'h79;
      default: ssdOut = 7'h71;
    endcase
  end

endmodule
